// File: rtl/arb_out_buffer.sv
// Elastic 32-bit buffer between the rrp_arbiter and the board FIFO write port,
// with optional heartbeat marker injection and DAQ word/overflow counters.
`timescale 1ns/1ps

module arb_out_buffer #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned READY_MARGIN = 4,
    parameter int unsigned HB_PERIOD    = 40_000_000,
    parameter logic [3:0]  HB_ID        = 4'b0110
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST,
    input  logic                  ARB_WRITE_OUT,
    input  logic [31:0]           ARB_DATA_OUT,
    output logic                  ARB_READY_OUT,
    input  logic                  FIFO_FULL,
    output logic                  FIFO_WRITE,
    output logic [31:0]           FIFO_DATA,
    input  logic                  HB_EN,
    output logic [ADDR_WIDTH:0]   FILL_LEVEL,
    output logic [31:0]           WORD_COUNT,
    output logic [15:0]           OVERFLOW_COUNT
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned FW    = ADDR_WIDTH + 1;
    localparam int unsigned TW    = $clog2(HB_PERIOD);

    localparam logic [FW-1:0] FILL_FULL  = FW'(DEPTH);
    localparam logic [FW-1:0] READY_TH   = FW'(DEPTH - READY_MARGIN);
    localparam logic [TW-1:0] TIMER_LAST = TW'(HB_PERIOD - 1);

    typedef enum logic [1:0] {
        HB_IDLE,
        HB_COUNT,
        HB_PENDING
    } hb_state_t;

    hb_state_t hb_state, hb_state_next;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [FW-1:0]         fill, fill_next;
    logic [TW-1:0]         hb_timer;
    logic [27:0]           hb_seq;

    logic hb_pending, hb_emit, hb_wrap;
    logic push, pop, drop;

    // A pending heartbeat wins the output slot, so buffer pops wait behind it.
    always_comb begin
        hb_pending = (hb_state == HB_PENDING);
        hb_emit    = hb_pending && !FIFO_FULL;
        hb_wrap    = (hb_timer == TIMER_LAST);
        pop        = !FIFO_FULL && !hb_pending && (fill != '0);
        push       = ARB_WRITE_OUT && ((fill != FILL_FULL) || pop);
        drop       = ARB_WRITE_OUT && !push;
        fill_next  = fill;
        if (push && !pop)
            fill_next = fill + FW'(1);
        else if (!push && pop)
            fill_next = fill - FW'(1);
    end

    always_comb begin
        hb_state_next = hb_state;
        unique case (hb_state)
            HB_IDLE:    if (HB_EN) hb_state_next = HB_COUNT;
            HB_COUNT:   if (!HB_EN) hb_state_next = HB_IDLE;
                        else if (hb_wrap) hb_state_next = HB_PENDING;
            HB_PENDING: if (!HB_EN) hb_state_next = HB_IDLE;
                        else if (!FIFO_FULL) hb_state_next = HB_COUNT;
            default:    hb_state_next = HB_IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST)
            hb_state <= HB_IDLE;
        else
            hb_state <= hb_state_next;
    end

    // The timer free-runs through PENDING; a wrap there merges into the pending marker.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            hb_timer <= '0;
            hb_seq   <= '0;
        end else begin
            if (hb_state == HB_IDLE || !HB_EN || hb_wrap)
                hb_timer <= '0;
            else
                hb_timer <= hb_timer + TW'(1);
            if (hb_emit)
                hb_seq <= hb_seq + 28'd1;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (push)
            mem[wr_ptr] <= ARB_DATA_OUT;
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill           <= '0;
            ARB_READY_OUT  <= 1'b0;
            OVERFLOW_COUNT <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (pop)
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            fill          <= fill_next;
            ARB_READY_OUT <= (fill_next < READY_TH);
            if (drop && (OVERFLOW_COUNT != '1))
                OVERFLOW_COUNT <= OVERFLOW_COUNT + 16'd1;
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            FIFO_WRITE <= 1'b0;
            FIFO_DATA  <= '0;
            WORD_COUNT <= '0;
        end else begin
            FIFO_WRITE <= hb_emit || pop;
            if (hb_emit)
                FIFO_DATA <= {HB_ID, hb_seq};
            else if (pop)
                FIFO_DATA <= mem[rd_ptr];
            if (hb_emit || pop)
                WORD_COUNT <= WORD_COUNT + 32'd1;
        end
    end

    assign FILL_LEVEL = fill;

endmodule

// File: tb/tb_arb_out_buffer.sv
// Scoreboard bench for arb_out_buffer: stimulus queues expected output words,
// a negedge monitor pops and compares every FIFO_WRITE.
`timescale 1ns/1ps

module tb_arb_out_buffer;

    logic        BUS_CLK;
    logic        BUS_RST;
    logic        ARB_WRITE_OUT;
    logic [31:0] ARB_DATA_OUT;
    logic        ARB_READY_OUT;
    logic        FIFO_FULL;
    logic        FIFO_WRITE;
    logic [31:0] FIFO_DATA;
    logic        HB_EN;
    logic [5:0]  FILL_LEVEL;
    logic [31:0] WORD_COUNT;
    logic [15:0] OVERFLOW_COUNT;

    arb_out_buffer #(
        .ADDR_WIDTH   (5),
        .READY_MARGIN (4),
        .HB_PERIOD    (16),
        .HB_ID        (4'b0110)
    ) dut (
        .BUS_CLK        (BUS_CLK),
        .BUS_RST        (BUS_RST),
        .ARB_WRITE_OUT  (ARB_WRITE_OUT),
        .ARB_DATA_OUT   (ARB_DATA_OUT),
        .ARB_READY_OUT  (ARB_READY_OUT),
        .FIFO_FULL      (FIFO_FULL),
        .FIFO_WRITE     (FIFO_WRITE),
        .FIFO_DATA      (FIFO_DATA),
        .HB_EN          (HB_EN),
        .FILL_LEVEL     (FILL_LEVEL),
        .WORD_COUNT     (WORD_COUNT),
        .OVERFLOW_COUNT (OVERFLOW_COUNT)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          first_wr_cyc = -1;
    bit          hb_track    = 0;
    logic [31:0] exp_q[$];
    int          hb_cyc[$];
    logic [31:0] exp_w;

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    always @(posedge BUS_CLK) cyc <= cyc + 1;

    always @(negedge BUS_CLK) begin
        if (!BUS_RST && FIFO_WRITE) begin
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (hb_track && FIFO_DATA[31:28] == 4'h6) hb_cyc.push_back(cyc);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL out_word: got %h, expected no write", FIFO_DATA);
            end else begin
                exp_w = exp_q.pop_front();
                if (FIFO_DATA !== exp_w) begin
                    miscompares++;
                    $display("FAIL out_word: got %h, want %h", FIFO_DATA, exp_w);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name, input int unsigned budget);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || FILL_LEVEL != 0) && n < budget) begin
            @(negedge BUS_CLK);
            n++;
        end
        repeat (3) @(negedge BUS_CLK);
        check(name, {31'd0, (exp_q.size() == 0 && FILL_LEVEL == 0)}, 32'd1);
    endtask

    initial begin
        #100000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc;
        int n_acc;
        int c0;
        int n;
        bit fell;
        bit any_write;

        BUS_RST = 1'b1; ARB_WRITE_OUT = 1'b0; ARB_DATA_OUT = '0;
        FIFO_FULL = 1'b0; HB_EN = 1'b0;
        repeat (3) @(negedge BUS_CLK);
        check("rst_ready", {31'd0, ARB_READY_OUT}, 32'd0);
        check("rst_write", {31'd0, FIFO_WRITE}, 32'd0);
        check("rst_data", FIFO_DATA, 32'd0);
        check("rst_fill", {26'd0, FILL_LEVEL}, 32'd0);
        check("rst_wcnt", WORD_COUNT, 32'd0);
        check("rst_ovf", {16'd0, OVERFLOW_COUNT}, 32'd0);
        BUS_RST = 1'b0;
        @(negedge BUS_CLK);
        check("ready_after_rst", {31'd0, ARB_READY_OUT}, 32'd1);

        // Burst of 10 words, free-flowing output.
        acc_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge BUS_CLK);
            if (i == 1) acc_cyc = cyc;
            ARB_WRITE_OUT = 1'b1;
            ARB_DATA_OUT  = 32'h4000_0001 + 32'(i);
            exp_q.push_back(32'h4000_0001 + 32'(i));
        end
        @(negedge BUS_CLK);
        ARB_WRITE_OUT = 1'b0;
        wait_drain("burst_drain", 40);
        check("burst_latency", 32'(first_wr_cyc), 32'(acc_cyc + 1));
        check("burst_wcnt", WORD_COUNT, 32'd10);

        // Backpressure with a ready-honouring arbiter.
        @(negedge BUS_CLK);
        FIFO_FULL = 1'b1;
        n_acc = 0; fell = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge BUS_CLK);
            if (ARB_READY_OUT) begin
                ARB_WRITE_OUT = 1'b1;
                ARB_DATA_OUT  = 32'h2000_0000 + 32'(n_acc);
                exp_q.push_back(32'h2000_0000 + 32'(n_acc));
                n_acc++;
            end else begin
                ARB_WRITE_OUT = 1'b0;
                if (!fell) begin
                    fell = 1;
                    check("ready_fall_fill", {26'd0, FILL_LEVEL}, 32'd28);
                end
            end
        end
        check("bp_accepted", 32'(n_acc), 32'd28);
        check("bp_fill", {26'd0, FILL_LEVEL}, 32'd28);
        check("bp_ovf", {16'd0, OVERFLOW_COUNT}, 32'd0);
        FIFO_FULL = 1'b0;
        wait_drain("bp_drain", 60);
        check("bp_wcnt", WORD_COUNT, 32'd38);
        check("bp_ready_back", {31'd0, ARB_READY_OUT}, 32'd1);

        // Overflow: 40 forced writes into a stalled buffer.
        @(negedge BUS_CLK);
        FIFO_FULL = 1'b1;
        any_write = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge BUS_CLK);
            any_write |= FIFO_WRITE;
            ARB_WRITE_OUT = 1'b1;
            ARB_DATA_OUT  = 32'h3000_0000 + 32'(i);
            if (i < 32) exp_q.push_back(32'h3000_0000 + 32'(i));
        end
        @(negedge BUS_CLK);
        any_write |= FIFO_WRITE;
        check("ovf_fill", {26'd0, FILL_LEVEL}, 32'd32);
        check("ovf_count", {16'd0, OVERFLOW_COUNT}, 32'd8);
        check("ovf_no_write", {31'd0, any_write}, 32'd0);
        // Push into a full buffer in the same cycle as a pop must be accepted.
        FIFO_FULL     = 1'b0;
        ARB_DATA_OUT  = 32'h5555_0000;
        exp_q.push_back(32'h5555_0000);
        @(negedge BUS_CLK);
        ARB_WRITE_OUT = 1'b0;
        check("full_pushpop_fill", {26'd0, FILL_LEVEL}, 32'd32);
        check("full_pushpop_ovf", {16'd0, OVERFLOW_COUNT}, 32'd8);
        wait_drain("ovf_drain", 60);
        check("ovf_wcnt", WORD_COUNT, 32'd71);

        // Heartbeats on an idle input.
        exp_q.push_back(32'h6000_0000);
        exp_q.push_back(32'h6000_0001);
        exp_q.push_back(32'h6000_0002);
        hb_track = 1;
        @(negedge BUS_CLK);
        c0 = cyc;
        HB_EN = 1'b1;
        n = 0;
        while (hb_cyc.size() < 3 && n < 100) begin
            @(negedge BUS_CLK);
            n++;
        end
        HB_EN = 1'b0;
        hb_track = 0;
        check("hb_count", 32'(hb_cyc.size()), 32'd3);
        check("hb_first_cyc", 32'(hb_cyc.size() > 0 ? hb_cyc[0] - c0 : 0), 32'd18);
        check("hb_period1", 32'(hb_cyc.size() > 1 ? hb_cyc[1] - hb_cyc[0] : 0), 32'd16);
        check("hb_period2", 32'(hb_cyc.size() > 2 ? hb_cyc[2] - hb_cyc[1] : 0), 32'd16);
        wait_drain("hb_drain", 20);

        // Heartbeat merged during a long stall, emitted ahead of the backlog.
        exp_q.push_back(32'h6000_0003);
        @(negedge BUS_CLK);
        FIFO_FULL = 1'b1;
        HB_EN     = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge BUS_CLK);
            if (i < 3) begin
                ARB_WRITE_OUT = 1'b1;
                ARB_DATA_OUT  = 32'h1000_00A0 + 32'(i);
                exp_q.push_back(32'h1000_00A0 + 32'(i));
            end else begin
                ARB_WRITE_OUT = 1'b0;
            end
        end
        check("hbb_fill", {26'd0, FILL_LEVEL}, 32'd3);
        FIFO_FULL = 1'b0;
        wait_drain("hbb_drain", 6);
        HB_EN = 1'b0;
        check("hbb_wcnt", WORD_COUNT, 32'd78);

        // Reset pulse with 12 words buffered.
        @(negedge BUS_CLK);
        FIFO_FULL = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge BUS_CLK);
            ARB_WRITE_OUT = 1'b1;
            ARB_DATA_OUT  = 32'h7000_0000 + 32'(i);
        end
        @(negedge BUS_CLK);
        ARB_WRITE_OUT = 1'b0;
        check("rstm_fill_before", {26'd0, FILL_LEVEL}, 32'd12);
        FIFO_FULL = 1'b0;
        @(posedge BUS_CLK);
        #1;
        check("rstm_write_before", {31'd0, FIFO_WRITE}, 32'd1);
        check("rstm_data_before", FIFO_DATA, 32'h7000_0000);
        BUS_RST = 1'b1;
        #1;
        check("rstm_write_async", {31'd0, FIFO_WRITE}, 32'd0);
        check("rstm_fill", {26'd0, FILL_LEVEL}, 32'd0);
        check("rstm_wcnt", WORD_COUNT, 32'd0);
        check("rstm_ovf", {16'd0, OVERFLOW_COUNT}, 32'd0);
        repeat (2) @(negedge BUS_CLK);
        BUS_RST = 1'b0;
        repeat (20) @(negedge BUS_CLK);
        check("rstm_fill_after", {26'd0, FILL_LEVEL}, 32'd0);
        check("rstm_wcnt_after", WORD_COUNT, 32'd0);
        check("rstm_ready_after", {31'd0, ARB_READY_OUT}, 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
